mem_responder: RTL and testbench
================================

# mem_responder

Synchronous memory responder on the far side of the MDR. It accepts read and write requests addressed by the MAR, then returns read data on the MDR's memory-input port, `MDataIn`. It holds a word-addressed 32-bit RAM and inserts a programmable number of wait states. A one-cycle done pulse marks completion, and the control unit advances its memory-access step on that pulse.

## Interface
- `ADDR_BITS`, 9: RAM index width; depth is 2^ADDR_BITS words.
- `LATENCY`, 2: wait states inserted before the array access; legal range 0–15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `mem_read` in 1: read request, level-sampled in IDLE.
- `mem_write` in 1: write request, level-sampled in IDLE.
- `MAR_addr` in 32: word address; only bits `[ADDR_BITS-1:0]` are used.
- `MDR_data` in 32: write data from the MDR output.
- `MDataIn` out 32: registered read data, wired to the MDR memory-input port.
- `mem_done` out 1: one-cycle completion pulse, for both reads and writes.
- `mem_busy` out 1: high from request acceptance until the cycle `mem_done` is high, inclusive.
- `mem_err` out 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - Exactly one of `mem_read`/`mem_write` high at an edge: capture the address index, `MDR_data` and the operation; load the wait counter with `LATENCY`; go to WAIT. If `LATENCY`=0, go directly to ACCESS.
  - Both high: no capture; stay in IDLE; `mem_err`=1 for the next cycle.
  - Neither high: stay in IDLE.
- WAIT: decrement the counter each edge. When the counter reads 1 at an edge, go to ACCESS.
- ACCESS, on its exit edge:
  - Write: `ram[idx] <= captured data`.
  - Read: `MDataIn <= ram[idx]`.
  - Go to DONE.
- DONE: `mem_done`=1; the next edge returns to IDLE. Requests present in the DONE cycle are ignored; they are re-sampled in IDLE.
- Requests arriving in WAIT, ACCESS or DONE are ignored, not queued. Input changes after capture have no effect on the transaction in flight.
- Address wrap: `MAR_addr` bits above `ADDR_BITS-1` are ignored, so `0x200` aliases `0x000` at the default width.
- `MDataIn` changes only on read completion. Writes and rejected requests leave it unchanged.
- RAM contents are zero at simulation start and are not altered by `clr`.

## Timing
- Reset values, after an edge with `clr`=1: state IDLE, counter 0, `MDataIn`=0, `mem_done`=0, `mem_busy`=0, `mem_err`=0.
- `clr` has priority over every other input.
- Reset mid-operation:
  - In WAIT or ACCESS, the transaction is aborted: no RAM write, no `MDataIn` update, no `mem_done`.
  - A write whose ACCESS exit edge coincides with `clr`=1 is not committed.
- Latency: a request accepted at edge k gives `mem_done` high in the cycle following edge k+`LATENCY`+1.
  - Default `LATENCY`=2: done 3 cycles after acceptance.
  - `LATENCY`=0: done 1 cycle after acceptance.
- Read data is valid on `MDataIn` in the same cycle `mem_done` is high, and is held afterwards.
- `mem_busy` rises the cycle after acceptance and falls the cycle after `mem_done`.
- Minimum spacing between accepted requests is `LATENCY`+3 edges.
- `mem_err` is asserted alone; `mem_busy` stays 0.

## Test plan
- Reset, then idle: `clr`=1 for 2 cycles then 0, no requests for 5 cycles. `MDataIn`=0 and `mem_done`, `mem_busy`, `mem_err` all 0 throughout.
- Write then read at `LATENCY`=2:
  - Write `MAR_addr`=0x10, `MDR_data`=0x87654321: `mem_done` pulses 3 cycles after acceptance; `MDataIn` stays 0.
  - Then read 0x10: `MDataIn`=0x87654321 with `mem_done` 3 cycles after acceptance.
- Alias and ignored requests:
  - Write 0x12345678 to 0x205, then read 0x005: returns 0x12345678.
  - A second `mem_read` held high during WAIT is ignored: exactly one `mem_done` pulse.
- Conflict: `mem_read`=`mem_write`=1 in IDLE. `mem_err`=1 for exactly 1 cycle, `mem_busy`=0, RAM and `MDataIn` unchanged.
- Reset mid-write: write 0xDEADBEEF to 0x20, then `clr`=1 during WAIT. No `mem_done`; a later read of 0x20 returns its prior value 0x00000000.
- Zero-latency read: with `LATENCY`=0, a read of a preloaded word has `mem_done` and correct data 1 cycle after acceptance. Back-to-back reads are accepted every 3 edges.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed 32-bit RAM behind the MDR with programmable wait states.
// Each accepted read or write is answered by a one-cycle mem_done pulse.
module mem_responder #(
  parameter int ADDR_BITS = 9,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] MAR_addr,
  input  logic [31:0] MDR_data,
  output logic [31:0] MDataIn,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_BITS-1:0]  idx;
  logic [31:0]           wdata;
  logic                  is_write;
  logic [31:0]           ram [2**ADDR_BITS];
  logic                  req_one;
  logic                  req_both;
  logic                  addr_unused;

  // Request handshake: a request is a level on mem_read/mem_write sampled only
  // while IDLE; exactly one high is accepted, both high is rejected with a
  // mem_err pulse, and anything seen outside IDLE is dropped, never queued.
  assign req_one     = mem_read ^ mem_write;
  assign req_both    = mem_read & mem_write;
  assign addr_unused = ^MAR_addr[31:ADDR_BITS];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req_one) begin
          cnt_nxt   = LAT;
          state_nxt = (LATENCY == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      MDataIn  <= 32'd0;
      mem_err  <= 1'b0;
      idx      <= '0;
      wdata    <= 32'd0;
      is_write <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_err <= (state == S_IDLE) && req_both;
      if (state == S_IDLE && req_one) begin
        idx      <= MAR_addr[ADDR_BITS-1:0];
        wdata    <= MDR_data;
        is_write <= mem_write;
      end
      if (state == S_ACCESS && !is_write) MDataIn <= ram[idx];
    end
  end

  // The array has no reset; clr only blocks a write that would commit on the same edge.
  always_ff @(posedge clk) begin
    if (!clr && state == S_ACCESS && is_write) ram[idx] <= wdata;
  end

  assign mem_done  = (state == S_DONE);
  assign mem_busy  = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a cycle table on a LATENCY=2 instance plus
// hand sequences for reset at ACCESS exit and zero-latency back-to-back reads.
module tb_mem_responder;

  logic        clk;
  logic        clr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] MAR_addr;
  logic [31:0] MDR_data;

  logic [31:0] dout2, dout0;
  logic        done2, busy2, err2, done0, busy0, err0;
  logic [1:0]  st2, st0;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic        clr;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] dout;
    logic        done;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  mem_responder #(.ADDR_BITS(9), .LATENCY(2)) u_dut2 (
    .clk(clk), .clr(clr), .mem_read(mem_read), .mem_write(mem_write),
    .MAR_addr(MAR_addr), .MDR_data(MDR_data), .MDataIn(dout2),
    .mem_done(done2), .mem_busy(busy2), .mem_err(err2), .dbg_state(st2)
  );

  mem_responder #(.ADDR_BITS(9), .LATENCY(0)) u_dut0 (
    .clk(clk), .clr(clr), .mem_read(mem_read), .mem_write(mem_write),
    .MAR_addr(MAR_addr), .MDR_data(MDR_data), .MDataIn(dout0),
    .mem_done(done0), .mem_busy(busy0), .mem_err(err0), .dbg_state(st0)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] dout, input logic done,
                     input logic busy, input logic err);
    vec_t v;
    v.clr = c; v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
    v.dout = dout; v.done = done; v.busy = busy; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_done(input bit sel0);
    return sel0 ? done0 : done2;
  endfunction

  function automatic logic [31:0] sel_dout(input bit sel0);
    return sel0 ? dout0 : dout2;
  endfunction

  function automatic logic [2:0] sel_flags(input bit sel0);
    return sel0 ? {done0, busy0, err0} : {done2, busy2, err2};
  endfunction

  // driver: one request edge, then count edges until mem_done (bounded)
  task automatic run_req(input bit sel0, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int exp_lat, input bit chk_dout,
                         input logic [31:0] exp_dout, input string name);
    int n;
    mem_read = rd; mem_write = wr; MAR_addr = addr; MDR_data = data;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    MAR_addr = 32'h0000_01FF; MDR_data = 32'hFFFF_FFFF;
    n = 0;
    while (!sel_done(sel0) && n < 20) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    if (chk_dout) check({name, " data"}, 64'(sel_dout(sel0)), 64'(exp_dout));
    tick();
    check({name, " back to idle"}, 64'(sel_flags(sel0)), 64'd0);
  endtask

  initial begin
    int first, second, e;
    clr = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    MAR_addr = 32'd0; MDR_data = 32'd0;

    // table: clr rd wr addr data | MDataIn done busy err (after the edge)
    add(1,0,0,32'h0,   32'h0,          32'h0, 0,0,0);
    add(1,0,0,32'h0,   32'h0,          32'h0, 0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,32'h0,32'h0, 32'h0, 0,0,0);
    // write 0x10
    add(0,0,1,32'h10,  32'h8765_4321,  32'h0, 0,1,0);
    add(0,0,0,32'h11,  32'hFFFF_FFFF,  32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 1,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,0,0);
    // read 0x10
    add(0,1,0,32'h10,  32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 1,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,0,0);
    // aliased write to 0x205
    add(0,0,1,32'h205, 32'h1234_5678,  32'h8765_4321, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 1,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,0,0);
    // read 0x005 with mem_read held through WAIT, ACCESS and DONE
    add(0,1,0,32'h5,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,1,0,32'h5,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,1,0,32'h5,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,1,0,32'h5,   32'h0,          32'h1234_5678, 1,1,0);
    add(0,1,0,32'h5,   32'h0,          32'h1234_5678, 0,0,0);
    add(0,0,0,32'h0,   32'h0,          32'h1234_5678, 0,0,0);
    // conflict
    add(0,1,1,32'h10,  32'hAAAA_AAAA,  32'h1234_5678, 0,0,1);
    add(0,0,0,32'h0,   32'h0,          32'h1234_5678, 0,0,0);
    add(0,0,0,32'h0,   32'h0,          32'h1234_5678, 0,0,0);
    // write 0x20 aborted by clr in WAIT
    add(0,0,1,32'h20,  32'hDEAD_BEEF,  32'h1234_5678, 0,1,0);
    add(1,0,0,32'h0,   32'h0,          32'h0, 0,0,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,0,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,0,0);
    // read 0x10 (untouched by conflict), then 0x20 (never written)
    add(0,1,0,32'h10,  32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 1,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,0,0);
    add(0,1,0,32'h20,  32'h0,          32'h8765_4321, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h8765_4321, 0,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 1,1,0);
    add(0,0,0,32'h0,   32'h0,          32'h0, 0,0,0);

    foreach (vecs[i]) begin
      clr = vecs[i].clr; mem_read = vecs[i].rd; mem_write = vecs[i].wr;
      MAR_addr = vecs[i].addr; MDR_data = vecs[i].data;
      tick();
      check($sformatf("vec%0d", i), {dout2, done2, busy2, err2},
            {vecs[i].dout, vecs[i].done, vecs[i].busy, vecs[i].err});
    end
    clr = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

    // clr on the ACCESS exit edge of a write must not commit it
    mem_write = 1'b1; MAR_addr = 32'h30; MDR_data = 32'h5555_AAAA;
    tick();
    mem_write = 1'b0;
    tick();
    tick();
    check("access state before clr", 64'(st2), 64'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("access clr flags", {dout2, done2, busy2, err2}, 64'd0);
    tick();
    check("access clr no done", 64'(done2), 64'd0);
    run_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b1, 32'h8765_4321, "l2 rd10");
    run_req(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 3, 1'b1, 32'h0, "l2 rd30 aborted");

    // zero-latency instance: preload, single read, then back-to-back reads
    repeat (5) tick();
    run_req(1'b1, 1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 1, 1'b0, 32'h0, "l0 wr40");
    run_req(1'b1, 1'b0, 1'b1, 32'h41, 32'h0BAD_F00D, 1, 1'b0, 32'h0, "l0 wr41");
    run_req(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b1, 32'hCAFE_F00D, "l0 rd40");

    mem_read = 1'b1; MAR_addr = 32'h40;
    first = -1; second = -1; e = 0;
    while (second < 0 && e < 20) begin
      tick();
      e++;
      if (done0) begin
        if (first < 0) begin
          first = e;
          check("l0 b2b first data", 64'(dout0), 64'hCAFE_F00D);
          MAR_addr = 32'h41;
        end else begin
          second = e;
          check("l0 b2b second data", 64'(dout0), 64'h0BAD_F00D);
        end
      end
    end
    mem_read = 1'b0;
    check("l0 b2b first done edge", 64'(first), 64'd2);
    check("l0 b2b spacing", 64'(second - first), 64'd3);
    tick();
    tick();
    check("l0 final idle", {st0, done0, busy0, err0}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
